inv_mix_column_iter: RTL
========================

Name: inv_mix_column_iter

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath; the inverse of the combinational forward MixColumns stage used by the encryption round.
- Accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per clock.
- Returns the transformed state over a second valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.

Parameters:
- N, 8, byte width. Fixed at 8; other values are unsupported.
- NCOL, 4, number of state columns. Fixed at 4.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  state in; byte r of column c is in_data[127-32c-8r -: 8] (FIPS-197 order, s00 at MSB).
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  transformed state, same byte layout as in_data.

Behaviour:
- Reset values (asynchronous): state=IDLE, col_cnt=0, work register=0, in_ready=1, out_valid=0, out_data=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, capture in_data into the work register, set col_cnt=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, overwrite column col_cnt with InvMixColumn(column) and increment col_cnt. On the cycle col_cnt==3, go to DONE.
  - DONE: out_valid=1, out_data=work register, held stable. When out_ready=1, go to IDLE. Otherwise stay in DONE.
- Latency: out_valid rises exactly 4 clocks after the accepting edge.
- Minimum per-block period: 6 clocks (accept, 4x BUSY, 1 DONE handshake).
- in_ready is high only in IDLE. A new block is never accepted during BUSY or DONE, including the cycle where the DONE handshake completes.
- Column math: b = M·a, with M rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
  - Multiplication is in GF(2^8) modulo 0x11b.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). The test is on the operand's MSB.
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2, x4, x8 are repeated xtime.
- out_valid high with out_ready low: hold out_data and out_valid indefinitely.
- in_valid is ignored outside IDLE. in_data may change freely after acceptance.
- rst_n low mid-operation aborts the block immediately. All registers return to reset values, and no partial result is emitted.
- out_data is driven only from the work register; no combinational path from in_data.

Optional Feature:
- IMC_PARALLEL_EN defined: four column units are instantiated. BUSY lasts one cycle and transforms all columns in it, so out_valid rises 1 clock after acceptance. The handshake is otherwise identical.
- IMC_PARALLEL_EN undefined: one shared column unit and the 4-cycle iterative schedule described above.

Decomposition:
- Package aes_pkg:
  - state enum {IDLE, BUSY, DONE};
  - byte/column/state width localparams;
  - AES reduction constant 8'h1b;
  - functions xtime, gmul09, gmul0b, gmul0d, gmul0e.
- Sub-module inv_mix_single_column: purely combinational, 32-bit in, 32-bit out. One instance, or four when IMC_PARALLEL_EN is defined.

Test Plan:
- Single block, out_ready=1: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data=db135345_f20a225c_01010101_c6c6c6c6, out_valid rising 4 clocks after accept (1 with IMC_PARALLEL_EN).
- Backpressure: same input, out_ready=0 for 10 cycles -> out_valid and out_data stable; in_ready=0 throughout; a single transfer when out_ready=1.
- xtime MSB path: in_data=d5d5d7d6_4d7ebdf8_00000000_ffffffff -> out_data=d4d4d4d5_2d26314c_00000000_ffffffff.
- Back-to-back: in_valid held high with two distinct blocks -> second accepted only after the first's DONE handshake; results in order; period 6 clocks.
- Reset mid-BUSY: assert rst_n low after 2 BUSY cycles -> out_valid=0, out_data=0, in_ready=1. The next block is processed correctly with no stale columns.
- Random: 1000 random states checked against a reference model, with out_ready randomly toggling; no lost or duplicated outputs.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the InvMixColumns engine.
package aes_pkg;

  localparam int N       = 8;
  localparam int NCOL    = 4;
  localparam int COL_W   = N * 4;
  localparam int STATE_W = COL_W * NCOL;

  localparam logic [N-1:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_e;

  // Column 0 (bytes s00..s30) lives in the most significant slot.
  typedef logic [NCOL-1:0][COL_W-1:0] aes_state_t;

  function automatic logic [N-1:0] xtime(input logic [N-1:0] x);
    return {x[N-2:0], 1'b0} ^ (x[N-1] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [N-1:0] gmul09(input logic [N-1:0] x);
    logic [N-1:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [N-1:0] gmul0b(input logic [N-1:0] x);
    logic [N-1:0] x2;
    logic [N-1:0] x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [N-1:0] gmul0d(input logic [N-1:0] x);
    logic [N-1:0] x4;
    logic [N-1:0] x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [N-1:0] gmul0e(input logic [N-1:0] x);
    logic [N-1:0] x2;
    logic [N-1:0] x4;
    logic [N-1:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumn of one 32-bit column (byte 0 at the MSB).
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  logic [N-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [N-1:0] w_b0, w_b1, w_b2, w_b3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_b0 = gmul0e(w_a0) ^ gmul0b(w_a1) ^ gmul0d(w_a2) ^ gmul09(w_a3);
  assign w_b1 = gmul09(w_a0) ^ gmul0e(w_a1) ^ gmul0b(w_a2) ^ gmul0d(w_a3);
  assign w_b2 = gmul0d(w_a0) ^ gmul09(w_a1) ^ gmul0e(w_a2) ^ gmul0b(w_a3);
  assign w_b3 = gmul0b(w_a0) ^ gmul0d(w_a1) ^ gmul09(w_a2) ^ gmul0e(w_a3);

  assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/inv_mix_column_iter.sv
// Iterative AES InvMixColumns: one column per clock through a shared unit.
// Define IMC_PARALLEL_EN to transform all four columns in a single BUSY cycle.
module inv_mix_column_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  imc_state_e r_state;
  logic [1:0] r_col_cnt;
  aes_state_t r_work;
  logic       r_in_ready;
  logic       r_out_valid;

`ifdef IMC_PARALLEL_EN
  aes_state_t w_par_out;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    inv_mix_single_column u_col (
      .i_col (r_work[c]),
      .o_col (w_par_out[c])
    );
  end
`else
  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_out;

  // Column col_cnt sits at slot NCOL-1-col_cnt since column 0 is the MSB.
  assign w_col_in = r_work[2'd3 - r_col_cnt];

  inv_mix_single_column u_col (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );
`endif

  // NOTE: all state is written with non-blocking assignments so every flop
  // samples pre-edge values; the work register is reset as well because it
  // drives out_data directly and must read zero after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col_cnt   <= 2'd0;
      r_work      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work     <= in_data;
            r_col_cnt  <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
`ifdef IMC_PARALLEL_EN
          r_work      <= w_par_out;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
`else
          r_work[2'd3 - r_col_cnt] <= w_col_out;
          r_col_cnt                <= r_col_cnt + 2'd1;
          if (r_col_cnt == 2'd3) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
`endif
        end
        DONE: begin
          // in_ready only rises here, so nothing is accepted on the handshake edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;

endmodule
